// File: rtl/uart_pkg.sv
// Shared encodings for the UART TX queue: sequencer states, status word layout,
// and the start-handshake timeout.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_START = 2'd1,
    WAIT_DONE  = 2'd2
  } seq_state_e;

  localparam int COUNT_LSB          = 0;
  localparam int EMPTY_BIT          = 8;
  localparam int FULL_BIT           = 9;
  localparam int OVF_BIT            = 10;
  localparam int BUSY_BIT           = 11;
  localparam int WAIT_START_TIMEOUT = 4;

  function automatic logic [31:0] status_word(input logic       busy,
                                              input logic       ovf,
                                              input logic       full,
                                              input logic       empty,
                                              input logic [7:0] cnt);
    logic [31:0] w;
    w                   = '0;
    w[COUNT_LSB +: 8]   = cnt;
    w[EMPTY_BIT]        = empty;
    w[FULL_BIT]         = full;
    w[OVF_BIT]          = ovf;
    w[BUSY_BIT]         = busy;
    return w;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with head-of-queue lookahead; push when full and pop when
// empty are ignored. Reusable for the RX side.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop)      count_d = count_q + (AW+1)'(1);
    else if (do_pop && !do_push) count_d = count_q - (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: pointers alone define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// Bus-fed byte queue that launches bytes into UART_TX paced by its busy flag.
// Optional UART_TX_FIFO_IRQ_EN adds a registered drained-and-idle interrupt.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int          DEPTH       = 16,
  parameter logic [31:0] ADDR_DATA   = 32'h0000_0000,
  parameter logic [31:0] ADDR_STATUS = 32'h0000_0004
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_wdata,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        tx_dv,
  output logic [7:0]  tx_byte,
  input  logic        tx_active_l,
  output logic        irq_empty
);

  localparam int AW    = $clog2(DEPTH);
  localparam int TMO_W = $clog2(WAIT_START_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(WAIT_START_TIMEOUT - 1);

  seq_state_e       state_q, state_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             mem_ready_q, mem_ready_d;
  logic [31:0]      mem_rdata_q, mem_rdata_d;
  logic             tx_dv_q, tx_dv_d;
  logic [7:0]       tx_byte_q, tx_byte_d;
  logic             ovf_q, ovf_d;

  logic             sel, acc, is_wr, wr_data, rd_status, push, pop, busy;
  logic             full, empty;
  logic [7:0]       head;
  logic [AW:0]      count;
  logic             unused_wdata;

  assign unused_wdata = ^mem_wdata[31:8];

  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (mem_wdata[7:0]),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // One action per access: only the cycle before the ready pulse acts.
  always_comb begin
    sel         = mem_valid && (mem_addr == ADDR_DATA || mem_addr == ADDR_STATUS);
    acc         = sel && !mem_ready_q;
    is_wr       = (mem_wstrb != 4'b0);
    wr_data     = acc && is_wr && (mem_addr == ADDR_DATA);
    rd_status   = acc && !is_wr && (mem_addr == ADDR_STATUS);
    push        = wr_data && !full;
    pop         = (state_q == IDLE) && !empty && tx_active_l;
    busy        = (state_q != IDLE) || !tx_active_l;
    mem_ready_d = acc;
    mem_rdata_d = rd_status ? status_word(busy, ovf_q, full, empty, 8'(count)) : '0;
    ovf_d       = (wr_data && full) ? 1'b1 : (rd_status ? 1'b0 : ovf_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tmo_d   = '0;
    unique case (state_q)
      IDLE:       if (!empty && tx_active_l) state_d = WAIT_START;
      WAIT_START: begin
        // A core held in reset never goes active; give up without re-popping.
        if (!tx_active_l)           state_d = WAIT_DONE;
        else if (tmo_q == TMO_LAST) state_d = IDLE;
        else                        tmo_d   = tmo_q + TMO_W'(1);
      end
      WAIT_DONE:  if (tx_active_l) state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    tx_dv_d   = pop;
    tx_byte_d = pop ? head : tx_byte_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_ready_q <= 1'b0;
      mem_rdata_q <= '0;
      tx_dv_q     <= 1'b0;
      tx_byte_q   <= '0;
      ovf_q       <= 1'b0;
    end else begin
      mem_ready_q <= mem_ready_d;
      mem_rdata_q <= mem_rdata_d;
      tx_dv_q     <= tx_dv_d;
      tx_byte_q   <= tx_byte_d;
      ovf_q       <= ovf_d;
    end
  end

  assign mem_ready = mem_ready_q;
  assign mem_rdata = mem_rdata_q;
  assign tx_dv     = tx_dv_q;
  assign tx_byte   = tx_byte_q;

`ifdef UART_TX_FIFO_IRQ_EN
  logic irq_q, irq_d, armed_q, armed_d, irq_set, irq_clr;

  // Armed by a launch so a never-used queue does not raise the interrupt.
  always_comb begin
    irq_clr = (acc && is_wr && (mem_addr == ADDR_DATA)) || rd_status;
    irq_set = armed_q && empty && (state_q == IDLE) && tx_active_l;
    armed_d = pop ? 1'b1 : (irq_set ? 1'b0 : armed_q);
    irq_d   = irq_clr ? 1'b0 : (irq_set ? 1'b1 : irq_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_q   <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      irq_q   <= irq_d;
      armed_q <= armed_d;
    end
  end

  assign irq_empty = irq_q;
`else
  assign irq_empty = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: queue-level scoreboard plus a behavioural
// UART_TX core (4 clocks per bit, 10-bit frame) driving tx_active_l.
module tb_uart_tx_fifo;

  localparam int          DEPTH  = 16;
  localparam int          CPB    = 4;
  localparam logic [31:0] A_DATA = 32'h1000_0000;
  localparam logic [31:0] A_STAT = 32'h1000_0004;
  localparam logic [31:0] BUSY_M = 32'h0000_0800;

  logic        clk = 1'b0, rst = 1'b1, rst_e = 1'b1;
  logic        mem_valid = 1'b0;
  logic [31:0] mem_addr = '0, mem_wdata = '0;
  logic [3:0]  mem_wstrb = '0;
  logic        mem_ready, tx_dv, irq_empty;
  logic [31:0] mem_rdata;
  logic [7:0]  tx_byte;
  logic        tx_active_l = 1'b1;

  always #5 clk = ~clk;

  uart_tx_fifo #(.DEPTH(DEPTH), .ADDR_DATA(A_DATA), .ADDR_STATUS(A_STAT)) dut (
    .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .tx_dv(tx_dv), .tx_byte(tx_byte),
    .tx_active_l(tx_active_l), .irq_empty(irq_empty)
  );

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  // Behavioural UART_TX: goes active the cycle after tx_dv, frame of 10*CPB clocks.
  int         core_cnt = 0;
  logic       core_stall = 1'b0, core_ignore = 1'b0;
  logic [7:0] core_byte;
  logic [7:0] line [$];

  always @(posedge clk) rst_e <= rst;

  always @(posedge clk) begin
    if (rst) begin
      core_cnt    <= 0;
      tx_active_l <= 1'b1;
    end else if (core_cnt == 0) begin
      if (tx_dv && !core_ignore) begin
        core_cnt    <= 10 * CPB;
        tx_active_l <= 1'b0;
        core_byte   <= tx_byte;
      end
    end else if (!core_stall) begin
      if (core_cnt == 1) begin
        tx_active_l <= 1'b1;
        line.push_back(core_byte);
      end
      core_cnt <= core_cnt - 1;
    end
  end

  // Scoreboard: the queue contents and sticky overflow, as firmware would see them.
  typedef enum {K_NONE, K_WDATA, K_RSTAT, K_OTHER} kind_e;
  kind_e       acc_kind = K_NONE;
  logic [7:0]  acc_byte = '0;
  logic [7:0]  mq [$];
  logic        movf = 1'b0;
  logic [31:0] exp_stat = 32'h100;
  int          cyc = 0, dv_cnt = 0, dv_cyc = -100, rdy_cyc = -100, hi_cnt = 0;
  logic        gap_armed = 1'b0, prev_dv = 1'b0, prev_al = 1'b1, prev_rdy = 1'b0;
  logic [7:0]  dv_byte = '0;

  function automatic logic [31:0] mstat();
    int n = mq.size();
    return (32'(movf) << 10) | (32'(n == DEPTH) << 9) | (32'(n == 0) << 8) | 32'(n);
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (rst_e) begin
      mq.delete();
      movf      = 1'b0;
      gap_armed = 1'b0;
      chk("rst_ready", 32'(mem_ready), 0);
      chk("rst_dv", 32'(tx_dv), 0);
    end else begin
      if (mem_ready) begin
        rdy_cyc = cyc;
        chk("ready_pulse", 32'(prev_rdy), 0);
        chk("ready_has_access", 32'(acc_kind != K_NONE), 1);
        if (acc_kind == K_RSTAT) begin
          chk("status_model", mem_rdata & ~BUSY_M, exp_stat);
          movf = 1'b0;
        end else begin
          chk("rdata_zero", mem_rdata, 0);
        end
        if (acc_kind == K_WDATA) begin
          if (mq.size() == DEPTH) movf = 1'b1;
          else mq.push_back(acc_byte);
        end
      end
      if (tx_dv) begin
        dv_cnt++;
        dv_cyc  = cyc;
        dv_byte = tx_byte;
        chk("dv_single_cycle", 32'(prev_dv), 0);
        chk("dv_core_idle", 32'(prev_al), 1);
        chk("dv_queue_nonempty", 32'(mq.size() > 0), 1);
        if (gap_armed) begin
          chk("frame_gap_le1", 32'(hi_cnt <= 2), 1);
          gap_armed = 1'b0;
        end
        if (mq.size() > 0) chk("dv_byte", 32'(tx_byte), 32'(mq.pop_front()));
      end
      if (tx_active_l && !prev_al) begin
        gap_armed = (mq.size() > 0);
        hi_cnt    = 1;
      end else if (tx_active_l && !tx_dv) begin
        hi_cnt++;
      end
`ifndef UART_TX_FIFO_IRQ_EN
      chk("irq_tied_low", 32'(irq_empty), 0);
`endif
    end
    prev_dv  = tx_dv;
    prev_al  = tx_active_l;
    prev_rdy = mem_ready;
    exp_stat = mstat();
  end

  task automatic bus(input logic [31:0] addr, input logic [3:0] wstrb,
                     input logic [31:0] wdata, output logic [31:0] rd);
    logic got = 1'b0;
    @(posedge clk); #1;
    if (wstrb != 0 && addr == A_DATA)      acc_kind = K_WDATA;
    else if (wstrb == 0 && addr == A_STAT) acc_kind = K_RSTAT;
    else                                   acc_kind = K_OTHER;
    acc_byte  = wdata[7:0];
    mem_valid = 1'b1; mem_addr = addr; mem_wstrb = wstrb; mem_wdata = wdata;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (mem_ready) got = 1'b1;
    end
    chk("bus_ack", 32'(got), 1);
    rd = mem_rdata;
    @(posedge clk); #1;
    mem_valid = 1'b0; mem_wstrb = '0; acc_kind = K_NONE;
  endtask

  task automatic bus_wr(input logic [31:0] addr, input logic [31:0] d);
    logic [31:0] unused_rd;
    bus(addr, 4'hf, d, unused_rd);
  endtask

  task automatic bus_rd(input logic [31:0] addr, output logic [31:0] rd);
    bus(addr, 4'h0, 32'h0, rd);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(mq.size() == 0 && core_cnt == 0 && tx_active_l) && n < 3000) begin
      @(negedge clk); n++;
    end
    repeat (6) @(negedge clk);
    if (n >= 3000) chk("idle_timeout", 32'(n), 0);
  endtask

  initial begin
    logic [31:0] rd;
    int base, n;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_outputs", {mem_ready, tx_dv, irq_empty, tx_byte}, 0);
    chk("reset_rdata", mem_rdata, 0);
    bus_rd(A_STAT, rd); chk("idle_status", rd, 32'h100);

    // Single byte at idle
    line.delete(); base = dv_cnt;
    bus_wr(A_DATA, 32'h0000_AB55);
    repeat (3) @(negedge clk);
    chk("t1_dv_count", 32'(dv_cnt - base), 1);
    chk("t1_byte", 32'(dv_byte), 32'h55);
    chk("t1_latency", 32'(dv_cyc > rdy_cyc && dv_cyc - rdy_cyc <= 2), 1);
    bus_rd(A_STAT, rd); chk("t1_busy_status", rd, 32'h900);
    wait_idle();
`ifdef UART_TX_FIFO_IRQ_EN
    chk("irq_set_after_frame", 32'(irq_empty), 1);
`endif
    bus_rd(A_STAT, rd); chk("t1_done_status", rd, 32'h100);
`ifdef UART_TX_FIFO_IRQ_EN
    chk("irq_clr_on_read", 32'(irq_empty), 0);
`endif
    chk("t1_line_n", line.size(), 1);
    if (line.size() == 1) chk("t1_line", 32'(line[0]), 32'h55);

    // A,B,C back to back
    line.delete(); base = dv_cnt;
    bus_wr(A_DATA, 32'h41); bus_wr(A_DATA, 32'h42); bus_wr(A_DATA, 32'h43);
    wait_idle();
    chk("abc_dv_count", 32'(dv_cnt - base), 3);
    chk("abc_line_n", line.size(), 3);
    for (int i = 0; i < 3 && i < line.size(); i++) chk("abc_line", 32'(line[i]), 32'h41 + i);

    // Stalled core: overflow and sticky flag
    line.delete(); base = dv_cnt; core_stall = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) bus_wr(A_DATA, 32'h60 + i);
    bus_rd(A_STAT, rd); chk("ovf_status_1", rd, 32'hE10);
    bus_rd(A_STAT, rd); chk("ovf_status_2", rd, 32'hA10);
    core_stall = 1'b0;
    wait_idle();
    chk("ovf_dv_count", 32'(dv_cnt - base), DEPTH + 1);
    chk("ovf_line_n", line.size(), DEPTH + 1);
    for (int i = 0; i < DEPTH + 1 && i < line.size(); i++) chk("ovf_line", 32'(line[i]), 32'h60 + i);

    // Push landing in the same cycle as a pop at count 5
    line.delete(); core_stall = 1'b1;
    for (int i = 0; i < 6; i++) bus_wr(A_DATA, 32'h80 + i);
    bus_rd(A_STAT, rd); chk("pp_pre_status", rd, 32'h805);
    core_stall = 1'b0;
    n = 0;
    while (!tx_active_l && n < 200) begin @(negedge clk); n++; end
    chk("pp_core_done", 32'(tx_active_l), 1);
    bus_wr(A_DATA, 32'h86);
    bus_rd(A_STAT, rd); chk("pp_post_status", rd, 32'h805);
    wait_idle();
    chk("pp_line_n", line.size(), 7);
    for (int i = 0; i < 7 && i < line.size(); i++) chk("pp_line", 32'(line[i]), 32'h80 + i);

    // Core that never starts: timeout back to IDLE, no re-pop
    line.delete(); base = dv_cnt; core_ignore = 1'b1;
    bus_wr(A_DATA, 32'h77);
    repeat (12) @(negedge clk);
    chk("tmo_dv_count", 32'(dv_cnt - base), 1);
    bus_rd(A_STAT, rd); chk("tmo_status", rd, 32'h100);
    core_ignore = 1'b0;
    chk("tmo_line_n", line.size(), 0);

    // Data read returns 0, status write ignored, foreign address not acked
    base = dv_cnt;
    bus_rd(A_DATA, rd); chk("data_read_zero", rd, 0);
    bus_wr(A_STAT, 32'h99);
    repeat (4) @(negedge clk);
    chk("stat_write_no_push", 32'(dv_cnt - base), 0);
    bus_rd(A_STAT, rd); chk("stat_write_status", rd, 32'h100);
    @(posedge clk); #1 mem_valid = 1'b1; mem_addr = 32'h2000_0000; mem_wstrb = 4'hf;
    for (int i = 0; i < 3; i++) begin @(negedge clk); chk("unsel_no_ready", 32'(mem_ready), 0); end
    @(posedge clk); #1 mem_valid = 1'b0; mem_wstrb = '0;

    // Reset mid-frame with 3 queued
    line.delete();
    for (int i = 0; i < 4; i++) bus_wr(A_DATA, 32'h10 + i);
    repeat (5) @(negedge clk);
    bus_rd(A_STAT, rd); chk("rst_pre_status", rd, 32'h803);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_outputs", {mem_ready, tx_dv, irq_empty, tx_byte}, 0);
    bus_rd(A_STAT, rd); chk("rst_post_status", rd, 32'h100);
    bus_wr(A_DATA, 32'h21); bus_wr(A_DATA, 32'h22);
    wait_idle();
    chk("rst_line_n", line.size(), 2);
    for (int i = 0; i < 2 && i < line.size(); i++) chk("rst_line", 32'(line[i]), 32'h21 + i);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got %0d/%0d", n_pass, n_chk);
    $fatal(1);
  end

endmodule
